// File: rtl/port_arbiter.sv
// ---------------------------------------------------------------------------
// port_arbiter
//
// Two-requester arbiter in front of a single ports block. Each transaction
// is a fixed four-state sequence: IDLE -> ISSUE -> CAPTURE -> DONE. All
// outputs are registered.
//
// Build option:
//   PORT_ARB_ROUND_ROBIN_EN  defined   : contention goes to the requester that
//                                        was not the last owner.
//                            undefined : fixed priority, requester 0 wins.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req0/req1           transaction request, held high until ack
//   we0/we1             1 = write to port, 0 = read from port
//   addr0/addr1         port address
//   wdata0/wdata1       write value
//   ack0/ack1           one-cycle completion pulse
//   rdata               shared read result, valid with the matching ack
//   portaddr/portval    address and value to the ports block
//   get_enable          read strobe to the ports block
//   set_enable          write strobe to the ports block
//   portout             read value from the ports block
// ---------------------------------------------------------------------------
module port_arbiter #(
   parameter int unsigned WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [WORD_SIZE-1:0] addr0,
   input  logic [WORD_SIZE-1:0] addr1,
   input  logic [WORD_SIZE-1:0] wdata0,
   input  logic [WORD_SIZE-1:0] wdata1,
   output logic                 ack0,
   output logic                 ack1,
   output logic [WORD_SIZE-1:0] rdata,
   output logic [WORD_SIZE-1:0] portaddr,
   output logic [WORD_SIZE-1:0] portval,
   output logic                 get_enable,
   output logic                 set_enable,
   input  logic [WORD_SIZE-1:0] portout
);

   typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

   state_e               state_q, state_d;
   logic                 owner_q, owner_d;  // 0 = requester 0, 1 = requester 1
   logic                 we_q, we_d;
   logic                 ack0_q, ack0_d;
   logic                 ack1_q, ack1_d;
   logic                 get_en_q, get_en_d;
   logic                 set_en_q, set_en_d;
   logic [WORD_SIZE-1:0] rdata_q, rdata_d;
   logic [WORD_SIZE-1:0] portaddr_q, portaddr_d;
   logic [WORD_SIZE-1:0] portval_q, portval_d;
   logic                 grant1;

`ifdef PORT_ARB_ROUND_ROBIN_EN
   logic                 last_q, last_d;

   // Resets to 1 so the first contention goes to requester 0.
   assign grant1 = req1 & (~req0 | ~last_q);
`else
   assign grant1 = req1 & ~req0;
`endif

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      get_en_d   = 1'b0;
      set_en_d   = 1'b0;
      rdata_d    = rdata_q;
      portaddr_d = portaddr_q;
      portval_d  = portval_q;
`ifdef PORT_ARB_ROUND_ROBIN_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               // Everything the transaction needs is latched here, so later
               // changes on the requester's inputs cannot disturb it.
               owner_d    = grant1;
               we_d       = grant1 ? we1 : we0;
               portaddr_d = grant1 ? addr1 : addr0;
               portval_d  = grant1 ? wdata1 : wdata0;
               set_en_d   = we_d;
               get_en_d   = ~we_d;
               state_d    = StIssue;
`ifdef PORT_ARB_ROUND_ROBIN_EN
               last_d     = grant1;
`endif
            end
         end
         StIssue: begin
            state_d = StCapture;
         end
         StCapture: begin
            if (!we_q) begin
               rdata_d = portout;
            end
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         get_en_q   <= 1'b0;
         set_en_q   <= 1'b0;
         rdata_q    <= '0;
         portaddr_q <= '0;
         portval_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         get_en_q   <= get_en_d;
         set_en_q   <= set_en_d;
         rdata_q    <= rdata_d;
         portaddr_q <= portaddr_d;
         portval_q  <= portval_d;
      end
   end

`ifdef PORT_ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign get_enable = get_en_q;
   assign set_enable = set_en_q;
   assign rdata      = rdata_q;
   assign portaddr   = portaddr_q;
   assign portval    = portval_q;

endmodule

// File: tb/tb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_port_arbiter
//
// Directed bench for port_arbiter: reset values, single write, single read,
// contention ordering (depends on PORT_ARB_ROUND_ROBIN_EN), reset abort,
// input stability after grant, and a short random-traffic run.
// ---------------------------------------------------------------------------
module tb_port_arbiter;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic         we0 = 1'b0, we1 = 1'b0;
   logic [W-1:0] addr0 = '0, addr1 = '0;
   logic [W-1:0] wdata0 = '0, wdata1 = '0;
   logic         ack0, ack1;
   logic [W-1:0] rdata, portaddr, portval, portout = '0;
   logic         get_enable, set_enable;

   int n_cmp = 0;
   int n_err = 0;

   port_arbiter #(.WORD_SIZE(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0       (req0),
      .req1       (req1),
      .we0        (we0),
      .we1        (we1),
      .addr0      (addr0),
      .addr1      (addr1),
      .wdata0     (wdata0),
      .wdata1     (wdata1),
      .ack0       (ack0),
      .ack1       (ack1),
      .rdata      (rdata),
      .portaddr   (portaddr),
      .portval    (portval),
      .get_enable (get_enable),
      .set_enable (set_enable),
      .portout    (portout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      check_eq("strobe exclusive", {31'd0, get_enable & set_enable}, 32'd0);
      check_eq("ack exclusive", {31'd0, ack0 & ack1}, 32'd0);
   endtask

   int exp_g [4];
   int seen;
   int ack1_cnt;
   int outstanding;

   initial begin
`ifdef PORT_ARB_ROUND_ROBIN_EN
      exp_g = '{0, 1, 0, 1};
`else
      exp_g = '{0, 0, 0, 0};
`endif
      portout = 16'hBEEF;

      // Reset values while reset is held.
      @(posedge clk);
      @(posedge clk);
      #1;
      check_eq("rst ack0", {31'd0, ack0}, 0);
      check_eq("rst ack1", {31'd0, ack1}, 0);
      check_eq("rst get_enable", {31'd0, get_enable}, 0);
      check_eq("rst set_enable", {31'd0, set_enable}, 0);
      check_eq("rst rdata", {16'd0, rdata}, 0);
      check_eq("rst portaddr", {16'd0, portaddr}, 0);
      check_eq("rst portval", {16'd0, portval}, 0);
      reset = 1'b0;
      tick();
      check_eq("idle no strobe", {31'd0, get_enable | set_enable}, 0);

      // Write from requester 0.
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'd5; wdata0 = 16'd42;
      tick();
      check_eq("wr set_enable", {31'd0, set_enable}, 1);
      check_eq("wr get_enable", {31'd0, get_enable}, 0);
      check_eq("wr portaddr", {16'd0, portaddr}, 5);
      check_eq("wr portval", {16'd0, portval}, 42);
      check_eq("wr ack0 early", {31'd0, ack0}, 0);
      tick();
      check_eq("wr set_enable drop", {31'd0, set_enable}, 0);
      check_eq("wr ack0 capture", {31'd0, ack0}, 0);
      tick();
      check_eq("wr ack0", {31'd0, ack0}, 1);
      check_eq("wr ack1", {31'd0, ack1}, 0);
      check_eq("wr rdata unchanged", {16'd0, rdata}, 0);
      req0 = 1'b0;
      tick();
      check_eq("wr ack0 clear", {31'd0, ack0}, 0);
      check_eq("wr portaddr hold", {16'd0, portaddr}, 5);
      check_eq("wr portval hold", {16'd0, portval}, 42);

      // Read from requester 1.
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'd3; portout = 16'h1234;
      tick();
      check_eq("rd get_enable", {31'd0, get_enable}, 1);
      check_eq("rd set_enable", {31'd0, set_enable}, 0);
      check_eq("rd portaddr", {16'd0, portaddr}, 3);
      tick();
      check_eq("rd get_enable drop", {31'd0, get_enable}, 0);
      tick();
      check_eq("rd ack1", {31'd0, ack1}, 1);
      check_eq("rd ack0", {31'd0, ack0}, 0);
      check_eq("rd rdata", {16'd0, rdata}, 32'h1234);
      req1 = 1'b0;
      portout = 16'h5555;
      tick();
      check_eq("rd ack1 clear", {31'd0, ack1}, 0);
      check_eq("rd rdata hold", {16'd0, rdata}, 32'h1234);

      // Contention: both held for four transactions.
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'd10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'd20;
      ack1_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         seen = -1;
         for (int t = 0; t < 8 && seen < 0; t++) begin
            tick();
            if (ack0) seen = 0;
            else if (ack1) seen = 1;
         end
         if (ack1) ack1_cnt++;
         check_eq("contention grant", seen, exp_g[k]);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
`ifndef PORT_ARB_ROUND_ROBIN_EN
      check_eq("fixed prio no ack1", ack1_cnt, 0);
`else
      check_eq("rr ack1 count", ack1_cnt, 2);
`endif
      tick();

      // Reset during ISSUE of a write.
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'd8; wdata0 = 16'd77;
      tick();
      check_eq("abort set_enable pre", {31'd0, set_enable}, 1);
      reset = 1'b1;
      #1;
      check_eq("abort set_enable async", {31'd0, set_enable}, 0);
      check_eq("abort portaddr", {16'd0, portaddr}, 0);
      req0 = 1'b0;
      tick();
      check_eq("abort ack0", {31'd0, ack0}, 0);
      reset = 1'b0;
      tick();
      tick();
      check_eq("abort no retry ack0", {31'd0, ack0}, 0);
      check_eq("abort no retry strobe", {31'd0, set_enable | get_enable}, 0);
      // Fresh request completes normally.
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h11; wdata0 = 16'h22;
      tick();
      check_eq("fresh set_enable", {31'd0, set_enable}, 1);
      check_eq("fresh portaddr", {16'd0, portaddr}, 32'h11);
      tick();
      tick();
      check_eq("fresh ack0", {31'd0, ack0}, 1);
      req0 = 1'b0;
      tick();

      // Address change after grant must not matter.
      portout = 16'hAAAA;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'd7; wdata0 = 16'd1;
      tick();
      check_eq("stable portaddr grant", {16'd0, portaddr}, 7);
      addr0 = 16'd9; wdata0 = 16'd3;
      tick();
      check_eq("stable portaddr capture", {16'd0, portaddr}, 7);
      tick();
      check_eq("stable ack0", {31'd0, ack0}, 1);
      check_eq("stable portaddr done", {16'd0, portaddr}, 7);
      check_eq("stable portval done", {16'd0, portval}, 1);
      check_eq("stable rdata after write", {16'd0, rdata}, 0);
      req0 = 1'b0;
      tick();

      // Random traffic.
      outstanding = 0;
      for (int i = 0; i < 260; i++) begin
         if (i < 200) begin
            if (!req0 && $urandom_range(0, 2) == 0) begin
               req0 = 1'b1; we0 = 1'($urandom); addr0 = W'($urandom); wdata0 = W'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
               req1 = 1'b1; we1 = 1'($urandom); addr1 = W'($urandom); wdata1 = W'($urandom);
            end
         end
         portout = W'($urandom);
         tick();
         if (get_enable || set_enable) outstanding++;
         if (ack0 || ack1) outstanding--;
         check_eq("rand outstanding", {31'd0, outstanding >= 0 && outstanding <= 1}, 1);
         if (ack0) begin
            check_eq("rand ack0 had req", {31'd0, req0}, 1);
            req0 = 1'b0;
         end
         if (ack1) begin
            check_eq("rand ack1 had req", {31'd0, req1}, 1);
            req1 = 1'b0;
         end
      end
      check_eq("rand drained", {30'd0, req1, req0}, 0);
      check_eq("rand outstanding end", outstanding, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, giving the width of port address and data words (taken from parameters.v).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have req0 / req1, input, 1, requester 0/1 transaction request, held high until ack.
REQ-005 SHALL have we0 / we1, input, 1, requester 0/1 direction: 1 = output to port, 0 = input from port.
REQ-006 SHALL have addr0 / addr1, input, WORD_SIZE, requester 0/1 port address.
REQ-007 SHALL have wdata0 / wdata1, input, WORD_SIZE, requester 0/1 output value.
REQ-008 SHALL have ack0 / ack1, output, 1, one-cycle completion pulse to requester 0/1.
REQ-009 SHALL have rdata, output, WORD_SIZE, shared read result, valid while the matching ack is high.
REQ-010 SHALL have portaddr / portval, output, WORD_SIZE, address and value driven to the ports block.
REQ-011 SHALL have get_enable / set_enable, output, 1, input and output strobes to the ports block.
REQ-012 SHALL have portout, input, WORD_SIZE, read value returned by the ports block.

Function
REQ-013 SHALL implement states IDLE, ISSUE, CAPTURE, DONE; all outputs registered.
REQ-014 In IDLE with any req high, SHALL select a winner, latch owner, we, addr, wdata, and go to ISSUE; with no req, stay in IDLE.
REQ-015 In ISSUE, SHALL drive portaddr = latched addr, portval = latched wdata, and assert get_enable (we=0) or set_enable (we=1) for exactly that one cycle; then go to CAPTURE.
REQ-016 get_enable and set_enable SHALL never be high in the same cycle; both SHALL be low outside ISSUE.
REQ-017 On the edge leaving CAPTURE, SHALL load rdata from portout for reads (rdata unchanged for writes), set the owner's ack, and go to DONE.
REQ-018 In DONE, SHALL hold exactly one owner ack high, then clear it and return to IDLE on the next edge.
REQ-019 Latency SHALL be fixed: ack rises on the second rising edge after the edge that samples req; peak throughput one transaction per 4 cycles.
REQ-020 A req still high in the first IDLE cycle after DONE SHALL be treated as a new transaction.
REQ-021 Non-winning requester SHALL keep waiting with no ack; its inputs SHALL be ignored until it is granted.
REQ-022 Changes to a granted requester's inputs after the grant edge SHALL NOT affect the transaction in progress.
REQ-023 portaddr and portval SHALL hold their last values outside ISSUE.

Reset
REQ-024 While reset is high, state SHALL be IDLE; ack0, ack1, get_enable, and set_enable SHALL be 0; rdata, portaddr, and portval SHALL be 0; last-owner SHALL be 1.
REQ-025 Reset mid-transaction SHALL abort it immediately: strobes drop asynchronously, no ack is issued, and the transaction is not retried.
REQ-026 After reset deasserts, the first arbitration SHALL occur on the first rising edge with reset low.

Configuration
REQ-027 Macro PORT_ARB_ROUND_ROBIN_EN defined: with both req high in IDLE, SHALL grant the requester that was not the last owner; a sole requester always wins.
REQ-028 With PORT_ARB_ROUND_ROBIN_EN defined, last-owner SHALL update at each grant; first contention after reset SHALL go to requester 0.
REQ-029 PORT_ARB_ROUND_ROBIN_EN undefined: SHALL use fixed priority, with requester 0 always winning contention; last-owner logic is absent.

Verification
REQ-030 Scenario: req0=1, we0=1, addr0=5, wdata0=42; then set_enable is high for 1 cycle with portaddr=5 and portval=42, ack0 pulses once 2 edges after sampling, and rdata is unchanged.
REQ-031 Scenario: req1=1, we1=0, addr1=3, portout=0x1234 during CAPTURE; then get_enable pulses once with portaddr=3, and ack1 is high with rdata=0x1234.
REQ-032 Scenario: req0 and req1 both held high for 4 transactions; with the round-robin macro, grants alternate 0,1,0,1; without it, grants are 0,0,0,0 while req1 receives no ack.
REQ-033 Scenario: reset asserted during an ISSUE cycle of a write; then set_enable drops without waiting for a clock edge, no ack appears, and state is IDLE, after which a fresh req0 completes normally.
REQ-034 Scenario: req0 write addr0=7, with addr0 changed to 9 one cycle after the grant; then portaddr=7.
REQ-035 Scenario: random traffic on both requesters; then get_enable and set_enable are never simultaneously high, and every ack matches exactly one granted request.
